read_burst: RTL and testbench
=============================

// Module: read_burst
// PURPOSE
//  Read-path companion of the controller's DDR write burst serializer.
//  - Captures BW-bit data beats from memory on both edges of clock.
//  - Pairs each beat pair into a 2*BW-bit word, one word per clock.
//  - Collects BL/2 words into one BL*BW-bit burst and hands it to the controller core
//    through a valid/ready handshake. Flags short (truncated) bursts and dropped bursts.
// PARAMETERS
//  BW  8  width of one DDR data beat (bits)
//  BL  8  beats per burst; even, >=2; words per burst WPB = BL/2
// PORTS
//  clock        in   1           single clock; low byte sampled on posedge, high byte on negedge
//  reset        in   1           asynchronous, active-low reset
//  dq_in        in   BW          data beat from memory
//  dq_valid     in   1           sampled at posedge with the low beat; marks a valid beat pair
//  word_out     out  2*BW        assembled word {high beat, low beat}
//  word_valid   out  1           word_out valid for this cycle (1-cycle pulse per word)
//  burst_data   out  BL*BW       completed burst; word i at [i*2*BW +: 2*BW]
//  burst_valid  out  1           burst_data held valid until accepted
//  burst_ready  in   1           consumer accepts burst when burst_valid & burst_ready at posedge
//  short_burst  out  1           1-cycle pulse: pair stream stopped before WPB words were collected
//  overflow     out  1           sticky: a completed burst was dropped; cleared only by reset
// BEHAVIOUR
//  Reset (reset=0, async):
//   - All registers clear, including the negedge high-beat register.
//   - All outputs 0; word count 0; output buffer EMPTY.
//  Capture, per posedge k:
//   - lo_reg <= dq_in; pend <= dq_valid.
//  Capture, per negedge k:
//   - hi_reg <= dq_in.
//  Word assembly at posedge k+1:
//   - If pend=1: word_out <= {hi_reg, lo_reg}; word_valid <= 1. Otherwise word_valid <= 0.
//   - Latency: dq_valid at posedge k -> word_valid at posedge k+1 (1 clock).
//  Burst assembly (counter wcnt, 0..WPB-1):
//   - Each assembled word is written into assembly slot wcnt at the same edge.
//   - wcnt increments; it wraps to 0 after slot WPB-1.
//   - Slot WPB-1 written: the full burst (assembly slots plus the new word) moves to the
//     output register at that same edge. burst_valid rises together with the last word_valid.
//   - Posedge with pend=0 and wcnt!=0: wcnt <= 0, partial data discarded, short_burst pulses 1 cycle.
//  Output buffer FSM:
//   - EMPTY -> FULL on burst completion.
//   - FULL -> EMPTY on burst_valid & burst_ready.
//   - FULL & completion & burst_ready in the same cycle: stays FULL, loaded with the new burst (no bubble).
//   - FULL & completion & !burst_ready: new burst dropped, old burst kept, overflow <= 1.
//   - burst_data is stable while burst_valid=1 and !burst_ready.
//  Word-level assembly never stalls; back-to-back bursts with dq_valid held high are legal.
//  Reset mid-burst: partial words are lost; no short_burst pulse is generated.
//  No arithmetic apart from the wcnt counter ($clog2(WPB) bits, minimum 1).
// TESTING
//  1. Reset: hold reset=0 with dq toggling
//     -> all outputs 0; release -> word_valid=0 until first dq_valid.
//  2. Single word: dq_valid=1 for one clock, lo=8'hA5, hi=8'h3C
//     -> word_out=16'h3CA5, word_valid high exactly 1 cycle, 1 clock later.
//  3. Full burst, BL=8: beats 01..08
//     -> burst_data=64'h0807_0605_0403_0201, burst_valid high at the 4th word_valid.
//  4. Back-to-back bursts, burst_ready=1
//     -> two bursts delivered with no gap, overflow stays 0.
//  5. Backpressure: burst_ready=0 for 2 bursts
//     -> first burst held, overflow=1; burst_ready=1 -> first burst accepted.
//  6. Truncation: dq_valid low after 2 words
//     -> short_burst 1-cycle pulse, no burst_valid, next full burst lands in slot 0.

Source files
------------

// File: rtl/read_burst_if.sv
// Read-burst bus: DDR beat input, assembled word output, and the burst
// hand-off to the controller core.
//   dq_in/dq_valid          memory -> read_burst beat stream
//   word_out/word_valid     per-clock assembled word {high beat, low beat}
//   burst_data/burst_valid  completed burst, held until burst_ready
//   burst_ready             core accepts the held burst
//   short_burst/overflow    truncated-burst pulse / sticky dropped-burst flag
// slave: the read_burst side. master: the memory/core side.
interface read_burst_if #(
    parameter int BW = 8,
    parameter int BL = 8
);
    logic [BW-1:0]    dq_in;
    logic             dq_valid;
    logic [2*BW-1:0]  word_out;
    logic             word_valid;
    logic [BL*BW-1:0] burst_data;
    logic             burst_valid;
    logic             burst_ready;
    logic             short_burst;
    logic             overflow;

    modport slave (
        input  dq_in, dq_valid, burst_ready,
        output word_out, word_valid, burst_data, burst_valid, short_burst, overflow
    );

    modport master (
        output dq_in, dq_valid, burst_ready,
        input  word_out, word_valid, burst_data, burst_valid, short_burst, overflow
    );
endinterface

// File: rtl/read_burst.sv
// DDR read-path burst assembler.
// Captures the low beat on posedge and the high beat on negedge, forms one
// 2*BW word per clock, gathers BL/2 words into a burst and hands the burst to
// the core through a single-entry valid/ready buffer.
// Ports:
//   clock   single clock, both edges used for beat capture
//   reset   asynchronous, active-low
//   bus     read_burst_if.slave (beat input, word/burst outputs, flags)
//
// Output buffer states:
//   state | meaning
//   EMPTY | no burst held, burst_valid=0
//   FULL  | burst held in burst_data, burst_valid=1 until accepted
module read_burst #(
    parameter int BW = 8,
    parameter int BL = 8
) (
    input logic      clock,
    input logic      reset,
    read_burst_if.slave bus
);
    localparam int WPB = BL / 2;
    localparam int WW  = 2 * BW;
    localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [CW-1:0] LAST = CW'(WPB - 1);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t       state_q, state_d;
    logic [BW-1:0]    lo_reg, hi_reg;
    logic             pend;
    logic [WW-1:0]    word_q;
    logic             word_valid_q;
    logic [CW-1:0]    wcnt;
    logic [BL*BW-1:0] asm_q;
    logic [BL*BW-1:0] burst_q;
    logic [BL*BW-1:0] burst_next;
    logic             short_q;
    logic             ovf_q;
    logic [WW-1:0]    new_word;
    logic             complete;
    logic             load;
    logic             ovf_set;

    // hi_reg holds the beat from the negedge between the two posedges, so at
    // posedge k+1 it pairs with lo_reg captured at posedge k.
    assign new_word = {hi_reg, lo_reg};
    assign complete = pend && (wcnt == LAST);

    // Last slot comes straight from the word being assembled this edge.
    always_comb begin
        burst_next = asm_q;
        burst_next[(WPB-1)*WW +: WW] = new_word;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (bus.burst_ready) begin
                    if (complete) load = 1'b1;
                    else          state_d = EMPTY;
                end else if (complete) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) hi_reg <= '0;
        else        hi_reg <= bus.dq_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lo_reg       <= '0;
            pend         <= 1'b0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            wcnt         <= '0;
            asm_q        <= '0;
            burst_q      <= '0;
            short_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            lo_reg       <= bus.dq_in;
            pend         <= bus.dq_valid;
            word_valid_q <= pend;
            short_q      <= 1'b0;
            if (pend) begin
                word_q <= new_word;
                for (int i = 0; i < WPB - 1; i++) begin
                    if (wcnt == CW'(i)) asm_q[i*WW +: WW] <= new_word;
                end
                if (wcnt == LAST) wcnt <= '0;
                else              wcnt <= wcnt + CW'(1);
            end else if (wcnt != '0) begin
                wcnt    <= '0;
                short_q <= 1'b1;
            end
            if (load)    burst_q <= burst_next;
            if (ovf_set) ovf_q   <= 1'b1;
        end
    end

    assign bus.word_out    = word_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.burst_data  = burst_q;
    assign bus.burst_valid = (state_q == FULL);
    assign bus.short_burst = short_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_read_burst.sv
module tb_read_burst;
    localparam int BW = 8;
    localparam int BL = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    read_burst_if #(.BW(BW), .BL(BL)) bus ();

    read_burst #(.BW(BW), .BL(BL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Low beat + valid set up for the posedge, high beat set up for the negedge.
    // Returns just after the negedge; outputs then reflect the posedge inside.
    task automatic step(input logic [7:0] lo, input logic [7:0] hi, input logic v);
        bus.dq_in    = lo;
        bus.dq_valid = v;
        @(posedge clock);
        #1;
        bus.dq_in = hi;
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        step(8'h00, 8'h00, 1'b0);
    endtask

    task automatic pairs(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++)
            step(base + 8'(2*i), base + 8'(2*i + 1), 1'b1);
    endtask

    initial begin
        bus.dq_in       = '0;
        bus.dq_valid    = 1'b0;
        bus.burst_ready = 1'b0;

        // Reset held while dq toggles
        for (int i = 0; i < 4; i++) step(8'hF0 ^ 8'(i), 8'h0F ^ 8'(i), 1'b1);
        chk("rst_word_out",    64'(bus.word_out),    64'h0);
        chk("rst_word_valid",  64'(bus.word_valid),  64'h0);
        chk("rst_burst_data",  bus.burst_data,       64'h0);
        chk("rst_burst_valid", 64'(bus.burst_valid), 64'h0);
        chk("rst_short",       64'(bus.short_burst), 64'h0);
        chk("rst_overflow",    64'(bus.overflow),    64'h0);
        reset = 1'b1;
        idle();
        chk("post_rst_wv", 64'(bus.word_valid), 64'h0);

        // Single word
        step(8'hA5, 8'h3C, 1'b1);
        chk("single_wv_lat", 64'(bus.word_valid), 64'h0);
        idle();
        chk("single_wv",   64'(bus.word_valid), 64'h1);
        chk("single_word", 64'(bus.word_out),   64'h3CA5);
        idle();
        chk("single_wv_off", 64'(bus.word_valid),  64'h0);
        chk("single_short",  64'(bus.short_burst), 64'h1);
        idle();
        chk("single_short_off", 64'(bus.short_burst), 64'h0);

        // Full burst, held with burst_ready low
        bus.burst_ready = 1'b0;
        pairs(8'h01, 4);
        chk("full_bv_early", 64'(bus.burst_valid), 64'h0);
        idle();
        chk("full_wv",   64'(bus.word_valid),  64'h1);
        chk("full_word", 64'(bus.word_out),    64'h0807);
        chk("full_bv",   64'(bus.burst_valid), 64'h1);
        chk("full_data", bus.burst_data,       64'h0807_0605_0403_0201);
        idle();
        idle();
        chk("full_hold_bv",   64'(bus.burst_valid), 64'h1);
        chk("full_hold_data", bus.burst_data,       64'h0807_0605_0403_0201);
        chk("full_no_short",  64'(bus.short_burst), 64'h0);
        bus.burst_ready = 1'b1;
        idle();
        chk("full_accept_bv", 64'(bus.burst_valid), 64'h0);

        // Back-to-back bursts, burst_ready high
        pairs(8'h11, 5);
        chk("b2b_bv1",   64'(bus.burst_valid), 64'h1);
        chk("b2b_data1", bus.burst_data,       64'h1817_1615_1413_1211);
        step(8'h1B, 8'h1C, 1'b1);
        chk("b2b_bv_gap", 64'(bus.burst_valid), 64'h0);
        step(8'h1D, 8'h1E, 1'b1);
        step(8'h1F, 8'h20, 1'b1);
        idle();
        chk("b2b_bv2",   64'(bus.burst_valid), 64'h1);
        chk("b2b_data2", bus.burst_data,       64'h201F_1E1D_1C1B_1A19);
        chk("b2b_ovf",   64'(bus.overflow),    64'h0);
        idle();
        chk("b2b_bv_done", 64'(bus.burst_valid), 64'h0);

        // Completion coinciding with acceptance of a held burst
        bus.burst_ready = 1'b0;
        pairs(8'h31, 8);
        chk("swap_bv1",   64'(bus.burst_valid), 64'h1);
        chk("swap_data1", bus.burst_data,       64'h3837_3635_3433_3231);
        bus.burst_ready = 1'b1;
        idle();
        chk("swap_bv2",   64'(bus.burst_valid), 64'h1);
        chk("swap_data2", bus.burst_data,       64'h403F_3E3D_3C3B_3A39);
        chk("swap_ovf",   64'(bus.overflow),    64'h0);
        idle();
        chk("swap_bv_done", 64'(bus.burst_valid), 64'h0);

        // Backpressure across two bursts
        bus.burst_ready = 1'b0;
        pairs(8'h41, 8);
        chk("bp_ovf_pre", 64'(bus.overflow), 64'h0);
        idle();
        chk("bp_ovf",  64'(bus.overflow),    64'h1);
        chk("bp_bv",   64'(bus.burst_valid), 64'h1);
        chk("bp_data", bus.burst_data,       64'h4847_4645_4443_4241);
        bus.burst_ready = 1'b1;
        idle();
        chk("bp_accept_bv", 64'(bus.burst_valid), 64'h0);
        chk("bp_ovf_stick", 64'(bus.overflow),    64'h1);

        // Truncated burst then a full one
        pairs(8'h51, 2);
        idle();
        chk("trunc_short_pre", 64'(bus.short_burst), 64'h0);
        idle();
        chk("trunc_short", 64'(bus.short_burst), 64'h1);
        chk("trunc_no_bv", 64'(bus.burst_valid), 64'h0);
        idle();
        chk("trunc_short_off", 64'(bus.short_burst), 64'h0);
        pairs(8'h61, 4);
        idle();
        chk("trunc_next_bv",   64'(bus.burst_valid), 64'h1);
        chk("trunc_next_data", bus.burst_data,       64'h6867_6665_6463_6261);
        idle();
        chk("trunc_next_done", 64'(bus.burst_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
